mod10_counter: RTL and testbench

//   Free-running decade (modulo-10) up-counter. Advances by one on every

---
 rtl/mod10_counter.sv | 40 ++++
 tb/tb_mod10_counter.sv | 107 ++++++++++
 2 files changed

// File: rtl/mod10_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mod10_counter
//  Brief    : Free-running modulo-MODULUS up-counter (decade / BCD digit stage)
//             with asynchronous active-high clear and self-recovery from
//             out-of-range states.
//  Revision : 1.0 - initial release
// ============================================================================
module mod10_counter #(
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_last = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic             w_wrap;

    // Using >= rather than == folds the wrap and any upset (illegal) state into
    // the same clear path, so the counter can never lock up above c_last.
    assign w_wrap = (r_count >= c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mod10_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod10_counter
//  Brief    : Directed-vector bench for mod10_counter (clk period 10, first
//             rising edge at t=5).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mod10_counter;

    logic       clk;
    logic       rst;
    logic [3:0] count;

    int n_vec;
    int n_err;

    mod10_counter #(
        .MODULUS(10),
        .WIDTH  (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    initial begin
        #5000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;

        // Reset held across the t=5 edge
        rst = 1'b1;
        #1;  chk("rst_t1", count, 4'd0);
        #5;  chk("rst_after_edge5", count, 4'd0);
        #4;  rst = 1'b0;                       // t=10

        // Edges at 15..95 give 1..9, edge at 105 wraps to 0
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("seq1_edge%0d", i), count, 4'(i % 10));
        end

        // t=106 -> assert reset between edges at t=112
        #6;  rst = 1'b1;
        #1;  chk("async_rst_t113", count, 4'd0);
        #13; chk("rst_hold_t126", count, 4'd0);
        #1;  rst = 1'b0;                       // t=127

        // 25 edges after release: 1,2,...,9,0,... ending on 5
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("seq2_edge%0d", i), count, 4'(i % 10));
        end
        chk("after_25_edges", count, 4'd5);

        // Asynchronous clear with a nonzero count, well before the next edge
        #3;  rst = 1'b1;
        #1;  chk("async_rst_midcount", count, 4'd0);
        @(posedge clk);
        #1;  chk("rst_hold_edge", count, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;  chk("restart_edge1", count, 4'd1);

        // Illegal states must recover to 0 on the next edge
        @(negedge clk);
        force dut.r_count = 4'd12;
        #1;  chk("forced_12", count, 4'd12);
        release dut.r_count;
        @(posedge clk);
        #1;  chk("recover_from_12", count, 4'd0);
        @(posedge clk);
        #1;  chk("after_recover_12", count, 4'd1);

        @(negedge clk);
        force dut.r_count = 4'd15;
        #1;  chk("forced_15", count, 4'd15);
        release dut.r_count;
        @(posedge clk);
        #1;  chk("recover_from_15", count, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
